mem_port_arbiter: RTL and testbench

- Shares the processor's single 16-bit memory port between two requesters:
  - the core datapath (C port);
  - a program/data loader (L port).
- Uses a req/gnt handshake, burst-limited round-robin arbitration and a registered memory command stage.
- Routes read data back to the issuing requester using a latency-matched tag pipeline.
- Sits between the core/loader and the memory macro.

---
 rtl/mem_port_arbiter.sv | 208 ++++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// ----------------
// Shares the processor's single memory port between two requesters:
//   C port = core datapath, L port = program/data loader.
// Each requester uses a req/gnt handshake. A transfer happens in any cycle
// where Req and Gnt are both high. Ownership is round-robin with a burst
// limit. The accepted command is registered onto the memory pins. Read data
// is routed back to the issuing port by a tag pipeline whose length matches
// the memory read latency.
//
// Optional feature: define ARB_STALL_CNT_EN to add the 16-bit saturating
// stall counters o_cStallCnt / o_lStallCnt. Each counts the cycles where
// that port's Req is high and its Gnt is low.
//
// Ports:
//   i_clk, i_rst           clock, asynchronous active-low reset
//   i_cReq/i_cWe/i_cAddr/i_cWData   core command (held until o_cGnt)
//   o_cGnt                 core handshake accept (combinational)
//   o_cRValid/o_cRData     core read return
//   i_lReq ... o_lRData    same set of signals for the loader
//   i_memData              memory read data
//   o_memData/o_memAddr    registered memory write data / address
//   o_memWrEnable/o_memRdEnable  registered memory strobes
module mem_port_arbiter #(
  parameter int DATA_W     = 16,
  parameter int ADDR_W     = 16,
  parameter int MAX_BURST  = 4,
  parameter int RD_LATENCY = 1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_cReq,
  input  logic              i_cWe,
  input  logic [ADDR_W-1:0] i_cAddr,
  input  logic [DATA_W-1:0] i_cWData,
  output logic              o_cGnt,
  output logic              o_cRValid,
  output logic [DATA_W-1:0] o_cRData,
  input  logic              i_lReq,
  input  logic              i_lWe,
  input  logic [ADDR_W-1:0] i_lAddr,
  input  logic [DATA_W-1:0] i_lWData,
  output logic              o_lGnt,
  output logic              o_lRValid,
  output logic [DATA_W-1:0] o_lRData,
  input  logic [DATA_W-1:0] i_memData,
  output logic [DATA_W-1:0] o_memData,
  output logic [ADDR_W-1:0] o_memAddr,
  output logic              o_memWrEnable,
  output logic              o_memRdEnable
`ifdef ARB_STALL_CNT_EN
  ,
  output logic [15:0]       o_cStallCnt,
  output logic [15:0]       o_lStallCnt
`endif
);

  typedef enum logic [1:0] {OWN_NONE, OWN_CORE, OWN_LOAD} owner_e;

  localparam int CNT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BURST - 1);

  owner_e             owner_q, owner_d;
  logic [CNT_W-1:0]   burst_cnt_q, burst_cnt_d;
  logic               last_load_q, last_load_d;   // 1: loader was served last
  logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]  mem_wdata_q, mem_wdata_d;
  logic               mem_we_q, mem_we_d;
  logic               mem_re_q, mem_re_d;
  logic [RD_LATENCY:0] tag_valid_q, tag_valid_d;
  logic [RD_LATENCY:0] tag_load_q, tag_load_d;
  logic [DATA_W-1:0]  c_rdata_q, c_rdata_d;
  logic [DATA_W-1:0]  l_rdata_q, l_rdata_d;

  logic              c_gnt, l_gnt, xfer;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic              c_rvalid, l_rvalid;

  // Grant follows the registered owner. Only one owner exists at a time,
  // so at most one grant can be high.
  always_comb begin
    c_gnt     = (owner_q == OWN_CORE) && i_cReq;
    l_gnt     = (owner_q == OWN_LOAD) && i_lReq;
    xfer      = c_gnt || l_gnt;
    sel_we    = c_gnt ? i_cWe    : i_lWe;
    sel_addr  = c_gnt ? i_cAddr  : i_lAddr;
    sel_wdata = c_gnt ? i_cWData : i_lWData;
  end

  // Owner selection. An owner that still has its Req high is transferring
  // in this cycle. It gives the port up when its burst budget runs out and
  // the other side is waiting. The count saturates at the last burst slot,
  // so a requester that arrives late waits for at most one more transfer.
  always_comb begin
    owner_d     = owner_q;
    burst_cnt_d = burst_cnt_q;
    last_load_d = last_load_q;
    case (owner_q)
      OWN_NONE: begin
        if (i_cReq && i_lReq) owner_d = last_load_q ? OWN_CORE : OWN_LOAD;
        else if (i_cReq)      owner_d = OWN_CORE;
        else if (i_lReq)      owner_d = OWN_LOAD;
      end
      OWN_CORE: begin
        if (!i_cReq)                                 owner_d = i_lReq ? OWN_LOAD : OWN_NONE;
        else if (i_lReq && burst_cnt_q == CNT_LAST)  owner_d = OWN_LOAD;
        else if (burst_cnt_q != CNT_LAST)            burst_cnt_d = burst_cnt_q + 1'b1;
      end
      OWN_LOAD: begin
        if (!i_lReq)                                 owner_d = i_cReq ? OWN_CORE : OWN_NONE;
        else if (i_cReq && burst_cnt_q == CNT_LAST)  owner_d = OWN_CORE;
        else if (burst_cnt_q != CNT_LAST)            burst_cnt_d = burst_cnt_q + 1'b1;
      end
      default: owner_d = OWN_NONE;
    endcase
    if (owner_d != owner_q) burst_cnt_d = '0;
    if (c_gnt)      last_load_d = 1'b0;
    else if (l_gnt) last_load_d = 1'b1;
  end

  // Command stage and read-tag pipeline. Tag stage 0 lines up with the read
  // strobe on the pins, and stage RD_LATENCY lines up with i_memData.
  always_comb begin
    mem_addr_d  = xfer ? sel_addr  : mem_addr_q;
    mem_wdata_d = xfer ? sel_wdata : mem_wdata_q;
    mem_we_d    = xfer && sel_we;
    mem_re_d    = xfer && !sel_we;
    tag_valid_d = {tag_valid_q[RD_LATENCY-1:0], xfer && !sel_we};
    tag_load_d  = {tag_load_q[RD_LATENCY-1:0], l_gnt};
  end

  // Read return. The tagged port sees the memory data directly. The other
  // port keeps showing the last data it received.
  always_comb begin
    c_rvalid  = tag_valid_q[RD_LATENCY] && !tag_load_q[RD_LATENCY];
    l_rvalid  = tag_valid_q[RD_LATENCY] &&  tag_load_q[RD_LATENCY];
    c_rdata_d = c_rvalid ? i_memData : c_rdata_q;
    l_rdata_d = l_rvalid ? i_memData : l_rdata_q;
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      owner_q     <= OWN_NONE;
      burst_cnt_q <= '0;
      last_load_q <= 1'b1;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_we_q    <= 1'b0;
      mem_re_q    <= 1'b0;
      tag_valid_q <= '0;
      tag_load_q  <= '0;
      c_rdata_q   <= '0;
      l_rdata_q   <= '0;
    end else begin
      owner_q     <= owner_d;
      burst_cnt_q <= burst_cnt_d;
      last_load_q <= last_load_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_we_q    <= mem_we_d;
      mem_re_q    <= mem_re_d;
      tag_valid_q <= tag_valid_d;
      tag_load_q  <= tag_load_d;
      c_rdata_q   <= c_rdata_d;
      l_rdata_q   <= l_rdata_d;
    end
  end

  assign o_cGnt        = c_gnt;
  assign o_lGnt        = l_gnt;
  assign o_cRValid     = c_rvalid;
  assign o_lRValid     = l_rvalid;
  assign o_cRData      = c_rdata_d;
  assign o_lRData      = l_rdata_d;
  assign o_memAddr     = mem_addr_q;
  assign o_memData     = mem_wdata_q;
  assign o_memWrEnable = mem_we_q;
  assign o_memRdEnable = mem_re_q;

`ifdef ARB_STALL_CNT_EN
  logic [15:0] c_stall_q, c_stall_d;
  logic [15:0] l_stall_q, l_stall_d;

  // Stall counters: cycles spent requesting without a grant, saturating.
  always_comb begin
    c_stall_d = c_stall_q;
    l_stall_d = l_stall_q;
    if (i_cReq && !c_gnt && c_stall_q != 16'hFFFF) c_stall_d = c_stall_q + 16'd1;
    if (i_lReq && !l_gnt && l_stall_q != 16'hFFFF) l_stall_d = l_stall_q + 16'd1;
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      c_stall_q <= '0;
      l_stall_q <= '0;
    end else begin
      c_stall_q <= c_stall_d;
      l_stall_q <= l_stall_d;
    end
  end

  assign o_cStallCnt = c_stall_q;
  assign o_lStallCnt = l_stall_q;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter with default parameters
// (DATA_W=16, ADDR_W=16, MAX_BURST=4, RD_LATENCY=1).
// A table of per-cycle vectors covers the core write, the loader read, and
// the in-order read return with a burst handover. Hand-written sequences
// cover a reset that lands on an in-flight read and the burst alternation
// seen when both requesters hold Req from reset.
module tb_mem_port_arbiter;

  logic        i_clk;
  logic        i_rst;
  logic        i_cReq, i_cWe, i_lReq, i_lWe;
  logic [15:0] i_cAddr, i_cWData, i_lAddr, i_lWData;
  logic        o_cGnt, o_cRValid, o_lGnt, o_lRValid;
  logic [15:0] o_cRData, o_lRData;
  logic [15:0] o_memData, o_memAddr;
  logic        o_memWrEnable, o_memRdEnable;
  logic [15:0] memRdata;
`ifdef ARB_STALL_CNT_EN
  logic [15:0] o_cStallCnt, o_lStallCnt;
  logic [15:0] lStallStart;
`endif

  int checks;
  int errors;

  typedef struct {
    logic        cReq;
    logic        cWe;
    logic [15:0] cAddr;
    logic [15:0] cWData;
    logic        lReq;
    logic        lWe;
    logic [15:0] lAddr;
    logic [15:0] lWData;
    logic        expCGnt;
    logic        expLGnt;
    logic        expWr;
    logic        expRd;
    logic [15:0] expAddr;
    logic [15:0] expMData;
    logic        expCRv;
    logic        expLRv;
    logic [15:0] expCRd;
    logic [15:0] expLRd;
  } vec_t;

  vec_t vecs [16];

  mem_port_arbiter dut (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .i_cReq        (i_cReq),
    .i_cWe         (i_cWe),
    .i_cAddr       (i_cAddr),
    .i_cWData      (i_cWData),
    .o_cGnt        (o_cGnt),
    .o_cRValid     (o_cRValid),
    .o_cRData      (o_cRData),
    .i_lReq        (i_lReq),
    .i_lWe         (i_lWe),
    .i_lAddr       (i_lAddr),
    .i_lWData      (i_lWData),
    .o_lGnt        (o_lGnt),
    .o_lRValid     (o_lRValid),
    .o_lRData      (o_lRData),
    .i_memData     (memRdata),
    .o_memData     (o_memData),
    .o_memAddr     (o_memAddr),
    .o_memWrEnable (o_memWrEnable),
    .o_memRdEnable (o_memRdEnable)
`ifdef ARB_STALL_CNT_EN
    ,
    .o_cStallCnt   (o_cStallCnt),
    .o_lStallCnt   (o_lStallCnt)
`endif
  );

  // Free-running clock with a 10-unit period
  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  // Memory model with one cycle of read latency. Address 0x0020 returns
  // 0x1234, and every other address returns the address itself as data.
  function automatic logic [15:0] memModel(input logic [15:0] a);
    return (a == 16'h0020) ? 16'h1234 : a;
  endfunction

  initial memRdata = 16'h0000;
  always @(posedge i_clk) if (o_memRdEnable) memRdata <= memModel(o_memAddr);

  // Guard against a hung simulation
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // One comparison: counts it and reports a mismatch
  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Drives one vector's inputs
  task automatic applyStimulus(input vec_t v);
    i_cReq   = v.cReq;
    i_cWe    = v.cWe;
    i_cAddr  = v.cAddr;
    i_cWData = v.cWData;
    i_lReq   = v.lReq;
    i_lWe    = v.lWe;
    i_lAddr  = v.lAddr;
    i_lWData = v.lWData;
  endtask

  // Every output must be zero while in reset
  task automatic checkAllZero(input string tag);
    checkOutput({tag, " cGnt"},    32'(o_cGnt),        32'd0);
    checkOutput({tag, " lGnt"},    32'(o_lGnt),        32'd0);
    checkOutput({tag, " cRValid"}, 32'(o_cRValid),     32'd0);
    checkOutput({tag, " lRValid"}, 32'(o_lRValid),     32'd0);
    checkOutput({tag, " cRData"},  32'(o_cRData),      32'd0);
    checkOutput({tag, " lRData"},  32'(o_lRData),      32'd0);
    checkOutput({tag, " memAddr"}, 32'(o_memAddr),     32'd0);
    checkOutput({tag, " memData"}, 32'(o_memData),     32'd0);
    checkOutput({tag, " memWr"},   32'(o_memWrEnable), 32'd0);
    checkOutput({tag, " memRd"},   32'(o_memRdEnable), 32'd0);
`ifdef ARB_STALL_CNT_EN
    checkOutput({tag, " cStall"},  32'(o_cStallCnt),   32'd0);
    checkOutput({tag, " lStall"},  32'(o_lStallCnt),   32'd0);
`endif
  endtask

  // Compares all outputs against one vector's expected values
  task automatic checkRow(input int i, input vec_t v);
    string t;
    t = $sformatf("row%0d", i);
    checkOutput({t, " cGnt"},    32'(o_cGnt),        32'(v.expCGnt));
    checkOutput({t, " lGnt"},    32'(o_lGnt),        32'(v.expLGnt));
    checkOutput({t, " memWr"},   32'(o_memWrEnable), 32'(v.expWr));
    checkOutput({t, " memRd"},   32'(o_memRdEnable), 32'(v.expRd));
    checkOutput({t, " memAddr"}, 32'(o_memAddr),     32'(v.expAddr));
    checkOutput({t, " memData"}, 32'(o_memData),     32'(v.expMData));
    checkOutput({t, " cRValid"}, 32'(o_cRValid),     32'(v.expCRv));
    checkOutput({t, " lRValid"}, 32'(o_lRValid),     32'(v.expLRv));
    checkOutput({t, " cRData"},  32'(o_cRData),      32'(v.expCRd));
    checkOutput({t, " lRData"},  32'(o_lRData),      32'(v.expLRd));
  endtask

  initial begin
    vec_t idle;
    logic expC, expL;
    checks = 0;
    errors = 0;
    idle = '{1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0,
             1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0};

    // Each row holds the inputs for one cycle: {cReq cWe cAddr cWData,
    // lReq lWe lAddr lWData}, followed by the outputs expected in that
    // cycle: {cGnt lGnt wr rd memAddr memData cRv lRv cRd lRd}.
    // Rows 0-2: core writes 0xBEEF to 0x0010.
    vecs[0]  = '{1'b1,1'b1,16'h0010,16'hBEEF, 1'b0,1'b0,16'h0000,16'h0000, 1'b0,1'b0,1'b0,1'b0,16'h0000,16'h0000, 1'b0,1'b0,16'h0000,16'h0000};
    vecs[1]  = '{1'b1,1'b1,16'h0010,16'hBEEF, 1'b0,1'b0,16'h0000,16'h0000, 1'b1,1'b0,1'b0,1'b0,16'h0000,16'h0000, 1'b0,1'b0,16'h0000,16'h0000};
    vecs[2]  = '{1'b0,1'b0,16'h0000,16'h0000, 1'b0,1'b0,16'h0000,16'h0000, 1'b0,1'b0,1'b1,1'b0,16'h0010,16'hBEEF, 1'b0,1'b0,16'h0000,16'h0000};
    // Rows 3-7: loader reads 0x0020, which returns 0x1234.
    vecs[3]  = '{1'b0,1'b0,16'h0000,16'h0000, 1'b1,1'b0,16'h0020,16'h0000, 1'b0,1'b0,1'b0,1'b0,16'h0010,16'hBEEF, 1'b0,1'b0,16'h0000,16'h0000};
    vecs[4]  = '{1'b0,1'b0,16'h0000,16'h0000, 1'b1,1'b0,16'h0020,16'h0000, 1'b0,1'b1,1'b0,1'b0,16'h0010,16'hBEEF, 1'b0,1'b0,16'h0000,16'h0000};
    vecs[5]  = '{1'b0,1'b0,16'h0000,16'h0000, 1'b0,1'b0,16'h0000,16'h0000, 1'b0,1'b0,1'b0,1'b1,16'h0020,16'h0000, 1'b0,1'b0,16'h0000,16'h0000};
    vecs[6]  = '{1'b0,1'b0,16'h0000,16'h0000, 1'b0,1'b0,16'h0000,16'h0000, 1'b0,1'b0,1'b0,1'b0,16'h0020,16'h0000, 1'b0,1'b1,16'h0000,16'h1234};
    vecs[7]  = '{1'b0,1'b0,16'h0000,16'h0000, 1'b0,1'b0,16'h0000,16'h0000, 1'b0,1'b0,1'b0,1'b0,16'h0020,16'h0000, 1'b0,1'b0,16'h0000,16'h1234};
    // Rows 8-15: core makes a 4-transfer burst (W 0x0100, W 0x0101, R 0x0001,
    // R 0x0002) while the loader waits on R 0x0003. Read data comes back
    // C, C, L in consecutive cycles.
    vecs[8]  = '{1'b1,1'b1,16'h0100,16'hAAAA, 1'b0,1'b0,16'h0000,16'h0000, 1'b0,1'b0,1'b0,1'b0,16'h0020,16'h0000, 1'b0,1'b0,16'h0000,16'h1234};
    vecs[9]  = '{1'b1,1'b1,16'h0100,16'hAAAA, 1'b1,1'b0,16'h0003,16'h0000, 1'b1,1'b0,1'b0,1'b0,16'h0020,16'h0000, 1'b0,1'b0,16'h0000,16'h1234};
    vecs[10] = '{1'b1,1'b1,16'h0101,16'hBBBB, 1'b1,1'b0,16'h0003,16'h0000, 1'b1,1'b0,1'b1,1'b0,16'h0100,16'hAAAA, 1'b0,1'b0,16'h0000,16'h1234};
    vecs[11] = '{1'b1,1'b0,16'h0001,16'h0000, 1'b1,1'b0,16'h0003,16'h0000, 1'b1,1'b0,1'b1,1'b0,16'h0101,16'hBBBB, 1'b0,1'b0,16'h0000,16'h1234};
    vecs[12] = '{1'b1,1'b0,16'h0002,16'h0000, 1'b1,1'b0,16'h0003,16'h0000, 1'b1,1'b0,1'b0,1'b1,16'h0001,16'h0000, 1'b0,1'b0,16'h0000,16'h1234};
    vecs[13] = '{1'b0,1'b0,16'h0000,16'h0000, 1'b1,1'b0,16'h0003,16'h0000, 1'b0,1'b1,1'b0,1'b1,16'h0002,16'h0000, 1'b1,1'b0,16'h0001,16'h1234};
    vecs[14] = '{1'b0,1'b0,16'h0000,16'h0000, 1'b0,1'b0,16'h0000,16'h0000, 1'b0,1'b0,1'b0,1'b1,16'h0003,16'h0000, 1'b1,1'b0,16'h0002,16'h1234};
    vecs[15] = '{1'b0,1'b0,16'h0000,16'h0000, 1'b0,1'b0,16'h0000,16'h0000, 1'b0,1'b0,1'b0,1'b0,16'h0003,16'h0000, 1'b0,1'b1,16'h0002,16'h0003};

    // Power-on reset
    i_rst = 1'b0;
    applyStimulus(idle);
    repeat (2) @(negedge i_clk);
    checkAllZero("reset");
    @(posedge i_clk);
    #1 i_rst = 1'b1;

    // Table-driven vectors: drive just after the edge, sample on the negedge
    for (int i = 0; i < 16; i++) begin
      applyStimulus(vecs[i]);
      @(negedge i_clk);
      checkRow(i, vecs[i]);
`ifdef ARB_STALL_CNT_EN
      if (i == 9) lStallStart = o_lStallCnt;
      if (i == 13) begin
        checkOutput("lStall burst delta", 32'(o_lStallCnt - lStallStart), 32'd4);
        checkOutput("lStall total",       32'(o_lStallCnt), 32'd5);
        checkOutput("cStall total",       32'(o_cStallCnt), 32'd2);
      end
`endif
      @(posedge i_clk);
      #1;
    end

    // Reset arrives in the cycle after a loader read transfer
    i_lReq = 1'b1; i_lWe = 1'b0; i_lAddr = 16'h0030; i_lWData = 16'h0000;
    @(negedge i_clk);
    checkOutput("rstseq lGnt idle", 32'(o_lGnt), 32'd0);
    @(posedge i_clk);
    #1;
    @(negedge i_clk);
    checkOutput("rstseq lGnt", 32'(o_lGnt), 32'd1);
    @(posedge i_clk);
    #1 i_lReq = 1'b0;
    @(negedge i_clk);
    checkOutput("rstseq memRd", 32'(o_memRdEnable), 32'd1);
    checkOutput("rstseq memAddr", 32'(o_memAddr), 32'h0030);
    i_rst = 1'b0;
    #1 checkAllZero("async reset");
    // Both requesters raise Req while reset is still asserted
    i_cReq = 1'b1; i_cWe = 1'b1; i_cAddr = 16'h0200; i_cWData = 16'h1111;
    i_lReq = 1'b1; i_lWe = 1'b1; i_lAddr = 16'h0300; i_lWData = 16'h2222;
    for (int i = 0; i < 2; i++) begin
      @(negedge i_clk);
      checkOutput($sformatf("rstseq lRValid %0d", i), 32'(o_lRValid), 32'd0);
      checkOutput($sformatf("rstseq gnt %0d", i), 32'({o_cGnt, o_lGnt}), 32'd0);
    end
    @(posedge i_clk);
    #1 i_rst = 1'b1;

    // Burst alternation: nothing in cycle 0, then core 4, loader 4, core 4
    for (int cyc = 0; cyc < 13; cyc++) begin
      expC = (cyc >= 1 && cyc <= 4) || (cyc >= 9 && cyc <= 12);
      expL = (cyc >= 5 && cyc <= 8);
      @(negedge i_clk);
      checkOutput($sformatf("burst cGnt c%0d", cyc), 32'(o_cGnt), 32'(expC));
      checkOutput($sformatf("burst lGnt c%0d", cyc), 32'(o_lGnt), 32'(expL));
      checkOutput($sformatf("burst both c%0d", cyc), 32'(o_cGnt & o_lGnt), 32'd0);
      checkOutput($sformatf("burst lRValid c%0d", cyc), 32'(o_lRValid), 32'd0);
      @(posedge i_clk);
      #1;
    end
    applyStimulus(idle);
    repeat (2) @(posedge i_clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
